// File: rtl/fpu_sp_pkg.sv
// Shared single-precision FPU definitions: FSM states, constants, field slices.
package fpu_sp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    UNPACK,
    SPECIAL,
    NORM_A,
    NORM_B,
    DIV_INIT,
    DIV_LOOP,
    NORM_Q,
    DENORM,
    ROUND,
    PACK,
    DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'hFFC00000;
  // 24 mantissa bits + guard + round + one spare bit for quotients below 1.0
  localparam int DIV_BITS = 27;

  localparam logic signed [9:0] EXP_BIAS  = 10'sd127;
  localparam logic signed [9:0] EXP_MAX   = 10'sd127;
  localparam logic signed [9:0] EXP_MIN   = -10'sd126;
  localparam logic signed [9:0] EXP_FLUSH = -10'sd151;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MAN_HI   = 22;
  localparam int MAN_LO   = 0;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } sp_t;

  function automatic logic is_nan(input sp_t x);
    return (x.e == 8'hFF) && (x.m != 23'd0);
  endfunction

  function automatic logic is_inf(input sp_t x);
    return (x.e == 8'hFF) && (x.m == 23'd0);
  endfunction

  function automatic logic is_zero(input sp_t x);
    return (x.e == 8'h00) && (x.m == 23'd0);
  endfunction

endpackage

// File: rtl/fpu_sp_mant_div.sv
// Iterative restoring divider for normalised 24-bit mantissas, one quotient bit per cycle.
module fpu_sp_mant_div
  import fpu_sp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [23:0]         a_m,
  input  logic [23:0]         b_m,
  output logic [DIV_BITS-1:0] q,
  output logic                rem_nz,
  output logic                done
);

  localparam logic [4:0] LAST = 5'(DIV_BITS - 1);

  // Remainder stays below 2*b_m after the shift, so 25 bits never overflow.
  logic [24:0] rem;
  logic [24:0] b_ext;
  logic [4:0]  cnt;
  logic        run;
  logic        ge;

  assign b_ext  = {1'b0, b_m};
  assign ge     = (rem >= b_ext);
  assign done   = run && (cnt == LAST);
  assign rem_nz = |rem;

  // Load on start, then shift in one quotient bit per cycle until cnt hits the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      rem <= '0;
      q   <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      rem <= {1'b0, a_m};
      q   <= '0;
    end else if (run) begin
      q   <= {q[DIV_BITS-2:0], ge};
      rem <= ge ? ((rem - b_ext) << 1) : (rem << 1);
      cnt <= cnt + 5'd1;
      if (cnt == LAST) run <= 1'b0;
    end
  end

endmodule

// File: rtl/fpu_sp_div.sv
// Multi-cycle IEEE-754 single-precision divider (din1 / din2), RNE, subnormals supported.
module fpu_sp_div
  import fpu_sp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        dval,
  output logic [31:0] result,
  output logic        rdy,
  output logic        busy
);

  state_t state, state_nx;

  sp_t               op_a, op_b;
  logic              a_s, b_s, z_s;
  logic signed [9:0] a_e, b_e, z_e;
  logic [23:0]       a_m, b_m, mant;
  logic              g, r, st;

  logic                md_start;
  logic [DIV_BITS-1:0] md_q;
  logic                md_rem_nz;
  logic                md_done;

  logic        spec_hit;
  logic [31:0] spec_res;
  logic        sgn;
  logic        round_up;

  fpu_sp_mant_div u_mdiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .a_m    (a_m),
    .b_m    (b_m),
    .q      (md_q),
    .rem_nz (md_rem_nz),
    .done   (md_done)
  );

  // Special-operand classification and its result, in priority order.
  always_comb begin
    sgn      = op_a.s ^ op_b.s;
    spec_hit = 1'b1;
    spec_res = QNAN;
    if (is_nan(op_a) || is_nan(op_b))         spec_res = QNAN;
    else if (is_inf(op_a) && is_inf(op_b))    spec_res = QNAN;
    else if (is_zero(op_a) && is_zero(op_b))  spec_res = QNAN;
    else if (is_inf(op_a))                    spec_res = {sgn, 8'hFF, 23'd0};
    else if (is_inf(op_b))                    spec_res = {sgn, 31'd0};
    else if (is_zero(op_b))                   spec_res = {sgn, 8'hFF, 23'd0};
    else if (is_zero(op_a))                   spec_res = {sgn, 31'd0};
    else                                      spec_hit = 1'b0;
  end

  assign round_up = g & (r | st | mant[0]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (dval) state_nx = UNPACK;
      UNPACK:   state_nx = SPECIAL;
      SPECIAL:  state_nx = spec_hit ? DONE : NORM_A;
      NORM_A:   if (a_m[23]) state_nx = NORM_B;
      NORM_B:   if (b_m[23]) state_nx = DIV_INIT;
      DIV_INIT: state_nx = DIV_LOOP;
      DIV_LOOP: if (md_done) state_nx = NORM_Q;
      NORM_Q:   state_nx = DENORM;
      DENORM: begin
        if (z_e < EXP_FLUSH)      state_nx = DONE;
        else if (!(z_e < EXP_MIN)) state_nx = ROUND;
      end
      ROUND:    state_nx = PACK;
      PACK:     state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Handshake outputs and divider kick-off are pure decodes of the state.
  always_comb begin
    busy     = (state != IDLE);
    rdy      = (state == DONE);
    md_start = (state == DIV_INIT);
  end

  // Datapath: operand capture, unpack, normalise, quotient align, denorm, round, pack.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else begin
      case (state)
        IDLE: if (dval) begin
          op_a <= '{s: din1[SIGN_BIT], e: din1[EXP_HI:EXP_LO], m: din1[MAN_HI:MAN_LO]};
          op_b <= '{s: din2[SIGN_BIT], e: din2[EXP_HI:EXP_LO], m: din2[MAN_HI:MAN_LO]};
        end
        UNPACK: begin
          a_s <= op_a.s;
          b_s <= op_b.s;
          a_e <= $signed({2'b00, op_a.e}) - EXP_BIAS;
          b_e <= $signed({2'b00, op_b.e}) - EXP_BIAS;
          a_m <= {1'b0, op_a.m};
          b_m <= {1'b0, op_b.m};
        end
        SPECIAL: begin
          if (spec_hit) begin
            result <= spec_res;
          end else begin
            // Subnormals have no hidden bit and sit at the minimum exponent.
            if (op_a.e == 8'd0) a_e <= EXP_MIN;
            else                a_m[23] <= 1'b1;
            if (op_b.e == 8'd0) b_e <= EXP_MIN;
            else                b_m[23] <= 1'b1;
          end
        end
        NORM_A: if (!a_m[23]) begin
          a_m <= a_m << 1;
          a_e <= a_e - 10'sd1;
        end
        NORM_B: if (!b_m[23]) begin
          b_m <= b_m << 1;
          b_e <= b_e - 10'sd1;
        end
        DIV_INIT: begin
          z_s <= a_s ^ b_s;
          z_e <= a_e - b_e;
        end
        NORM_Q: begin
          if (md_q[26]) begin
            mant <= md_q[26:3];
            g    <= md_q[2];
            r    <= md_q[1];
            st   <= md_q[0] | md_rem_nz;
          end else begin
            mant <= md_q[25:2];
            g    <= md_q[1];
            r    <= md_q[0];
            st   <= md_rem_nz;
            z_e  <= z_e - 10'sd1;
          end
        end
        DENORM: begin
          if (z_e < EXP_FLUSH) begin
            result <= {z_s, 31'd0};
          end else if (z_e < EXP_MIN) begin
            mant <= mant >> 1;
            g    <= mant[0];
            r    <= g;
            st   <= st | r;
            z_e  <= z_e + 10'sd1;
          end
        end
        ROUND: if (round_up) begin
          if (mant == 24'hFFFFFF) begin
            mant <= 24'h800000;
            z_e  <= z_e + 10'sd1;
          end else begin
            mant <= mant + 24'd1;
          end
        end
        PACK: begin
          if (z_e > EXP_MAX)  result <= {z_s, 8'hFF, 23'd0};
          else if (!mant[23]) result <= {z_s, 8'd0, mant[22:0]};
          else                result <= {z_s, 8'(z_e + EXP_BIAS), mant[22:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sp_div.sv
// Scoreboarded bench for fpu_sp_div against an exact integer-arithmetic reference.
module tb_fpu_sp_div;

  localparam logic [31:0] QN = 32'hFFC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dval = 1'b0;
  logic [31:0] din1 = '0;
  logic [31:0] din2 = '0;
  logic [31:0] result;
  logic        rdy;
  logic        busy;

  fpu_sp_div dut (
    .clk    (clk),
    .rst    (rst),
    .din1   (din1),
    .din2   (din2),
    .dval   (dval),
    .result (result),
    .rdy    (rdy),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          acc;
  } txn_t;

  txn_t sb[$];
  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  logic busy_drop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact quotient with wide integers, RNE to the target precision.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          output int lat);
    logic   s, g, st, rnz;
    int     ea, eb, xa, xb, lz, e, w, l, sh, ef;
    longint ma, mb, qq, m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    lat = 2;
    lz  = 0;
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return QN;
    if (ea == 255 && eb == 255) return QN;
    if (ea == 0 && ma == 0 && eb == 0 && mb == 0) return QN;
    if (ea == 255) return {s, 8'hFF, 23'd0};
    if (eb == 255) return {s, 31'd0};
    if (eb == 0 && mb == 0) return {s, 8'hFF, 23'd0};
    if (ea == 0 && ma == 0) return {s, 31'd0};
    if (ea == 0) begin
      xa = -126;
      while (ma < 64'h800000) begin ma = ma << 1; xa--; lz++; end
    end else begin
      ma = ma + 64'h800000; xa = ea - 127;
    end
    if (eb == 0) begin
      xb = -126;
      while (mb < 64'h800000) begin mb = mb << 1; xb--; lz++; end
    end else begin
      mb = mb + 64'h800000; xb = eb - 127;
    end
    qq  = (ma << 38) / mb;
    rnz = ((ma << 38) % mb) != 0;
    w   = xa - xb - 38;
    e   = (qq >= (64'd1 << 38)) ? (xa - xb) : (xa - xb - 1);
    if (e < -151) begin
      lat = 34 + lz;
      return {s, 31'd0};
    end
    lat = 36 + lz + ((e < -126) ? (-126 - e) : 0);
    l   = (e < -126) ? -149 : (e - 23);
    sh  = l - w;
    m   = qq >> sh;
    g   = ((qq >> (sh - 1)) & 64'd1) != 0;
    st  = ((qq & ((64'd1 << (sh - 1)) - 64'd1)) != 0) || rnz;
    if (g && (st || m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin m = 64'd1 << 23; l++; end
    if (m >= (64'd1 << 23)) begin
      ef = l + 23;
      if (ef > 127) return {s, 8'hFF, 23'd0};
      return {s, 8'(ef + 127), m[22:0]};
    end
    return {s, 8'd0, m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] rv;
    logic        s;
    int          k;
    rv = $urandom;
    s  = rv[31];
    k  = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3: return {s, 8'($urandom_range(100, 154)), rv[22:0]};
      4:          return rv;
      5:          return {s, 8'd0, rv[22:0] >> $urandom_range(0, 22)};
      6: case ($urandom_range(0, 3))
           0:       return {s, 31'd0};
           1:       return {s, 8'hFF, 23'd0};
           2:       return {s, 8'hFF, rv[22:0] | 23'd1};
           default: return {s, 8'd127, 23'd0};
         endcase
      7:          return {s, 8'($urandom_range(240, 254)), rv[22:0]};
      8:          return {s, 8'($urandom_range(1, 20)), rv[22:0]};
      default:    return {s, 8'($urandom_range(120, 134)), rv[22:0] & 23'h7F0000};
    endcase
  endfunction

  // Monitor: pop and compare on every rdy pulse; flag busy dropping mid-operation.
  always @(negedge clk) begin
    txn_t t;
    if (rdy) begin
      if (sb.size() == 0) begin
        tests++; errors++;
        $display("FAIL spurious_rdy: rdy with nothing outstanding, result=%h", result);
      end else begin
        t = sb.pop_front();
        tests++;
        if (result !== t.exp) begin
          errors++;
          $display("FAIL result %h/%h: got %h expected %h", t.a, t.b, result, t.exp);
        end
        tests++;
        if (cyc - t.acc != t.lat) begin
          errors++;
          $display("FAIL latency %h/%h: got %0d expected %0d", t.a, t.b, cyc - t.acc, t.lat);
        end
        tests++;
        if (busy !== 1'b1 || busy_drop) begin
          errors++;
          $display("FAIL busy %h/%h: busy=%b drop=%b expected busy held high", t.a, t.b, busy, busy_drop);
        end
        busy_drop = 1'b0;
      end
    end else if (sb.size() > 0 && !busy) begin
      busy_drop = 1'b1;
    end
  end

  task automatic wait_idle(output logic ok);
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin @(negedge clk); n++; end
    ok = !busy;
    if (!ok) begin
      tests++; errors++;
      $display("FAIL idle_timeout: busy=%b expected 0", busy);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic use_exp, input logic [31:0] exp_v);
    logic        ok;
    int          l;
    logic [31:0] e;
    wait_idle(ok);
    if (!ok) return;
    din1 = a; din2 = b; dval = 1'b1;
    @(posedge clk); #1;
    e = ref_div(a, b, l);
    if (use_exp) e = exp_v;
    sb.push_back('{a: a, b: b, exp: e, lat: l, acc: cyc});
    dval = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 500) begin @(negedge clk); n++; end
    if (sb.size() > 0) begin
      tests++; errors++;
      $display("FAIL drain_timeout: %0d outstanding expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  logic [31:0] dir_a [0:10] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                                32'h7F800000, 32'hC1000000, 32'h7FC00001, 32'h00800000,
                                32'h00000001, 32'h7F7FFFFF, 32'h00000001};
  logic [31:0] dir_b [0:10] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                                32'hFF800000, 32'h7F800000, 32'h3F800000, 32'h40000000,
                                32'h40000000, 32'h3F000000, 32'h3F800000};
  logic [31:0] dir_e [0:10] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'hFFC00000,
                                32'hFFC00000, 32'h80000000, 32'hFFC00000, 32'h00400000,
                                32'h00000000, 32'h7F800000, 32'h00000001};

  initial begin
    logic stable;
    logic ok;
    repeat (3) @(negedge clk);
    tests++;
    if (result !== 32'd0 || rdy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: result=%h rdy=%b busy=%b expected 0/0/0", result, rdy, busy);
    end
    rst = 1'b0;

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < 11; i++) begin
      issue(dir_a[i], dir_b[i], 1'b1, dir_e[i]);
      drain();
    end

    // A dval while busy must be ignored; result holds until the next op completes.
    issue(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000);
    repeat (5) @(negedge clk);
    din1 = 32'h3F800000; din2 = 32'h40400000; dval = 1'b1;
    @(negedge clk);
    dval = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    tests++;
    if (result !== 32'h40400000) begin
      errors++;
      $display("FAIL hold_after_done: got %h expected 40400000", result);
    end
    issue(32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (result !== 32'h40400000) stable = 1'b0;
    end
    tests++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_during_op: got %h expected 40400000", result);
    end
    drain();

    // Reset in the middle of the quotient loop aborts without a rdy.
    wait_idle(ok);
    din1 = 32'h3F800000; din2 = 32'h40400000; dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    tests++;
    if (result !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: result=%h busy=%b expected 0/0", result, busy);
    end
    issue(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000);
    drain();

    // Randomised operands against the reference model.
    for (int i = 0; i < 200; i++) issue(rnd_op(), rnd_op(), 1'b0, 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
